// File: rtl/merge_goback_sched.sv
// Two-lane CRC merge scheduler. Each lane XORs a packet's partial CRCs and queues it.
// A round-robin arbiter then feeds the queued results to one shared goback engine.
//
// merge_goback_lane: one lane's accumulator plus its small FIFO.
//   sop_i/eop_i/dval_i, packet_num_i, zero_num_i, dout_i : lane input stream
//   pop_i                                     : arbiter takes the head entry
//   head_*_o                                  : head entry fields
//   level_o, ovf_o, err_o                     : occupancy and event pulses
//
// merge_goback_sched: the top level.
//   a_* / b_* inputs : the two merge lanes
//   gb_valid/gb_ready and gb_lane/packet_num/zero_num/crc : the goback engine request
//   a_/b_ ovf, err, level : per-lane status

module merge_goback_lane #(
    parameter int DATA_W  = 32,
    parameter int PNUM_W  = 4,
    parameter int ZNUM_W  = 12,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              dval_i,
    input  logic [PNUM_W-1:0] packet_num_i,
    input  logic [ZNUM_W-1:0] zero_num_i,
    input  logic [DATA_W-1:0] dout_i,
    input  logic              pop_i,
    output logic [PNUM_W-1:0] head_pnum_o,
    output logic [ZNUM_W-1:0] head_znum_o,
    output logic [DATA_W-1:0] head_crc_o,
    output logic [FIFO_AW:0]  level_o,
    output logic              ovf_o,
    output logic              err_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = PNUM_W + ZNUM_W + DATA_W;

    logic              open_q, open_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              done;
    logic [DATA_W-1:0] crc;
    logic              full, push;
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]  level_q, level_d;
    logic              ovf_q, err_q;
    logic [EW-1:0]     mem_q [DEPTH];

    // A sop always restarts the accumulator, so a stale open packet is
    // simply overwritten by the new one.
    always_comb begin
        open_d = open_q;
        acc_d  = acc_q;
        done   = 1'b0;
        crc    = dout_i;
        if (dval_i) begin
            if (sop_i) begin
                open_d = !eop_i;
                acc_d  = dout_i;
                done   = eop_i;
                crc    = dout_i;
            end else if (open_q) begin
                acc_d = acc_q ^ dout_i;
                crc   = acc_q ^ dout_i;
                if (eop_i) begin
                    open_d = 1'b0;
                    done   = 1'b1;
                end
            end
        end
    end

    // Occupancy never exceeds DEPTH, so the MSB alone marks full.
    assign full = level_q[FIFO_AW];
    // A full queue can still take an entry if the head is leaving now.
    assign push = done & (!full | pop_i);

    always_comb begin
        level_d = level_q;
        unique case ({push, pop_i})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            open_q  <= 1'b0;
            acc_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            open_q  <= open_d;
            acc_q   <= acc_d;
            level_q <= level_d;
            ovf_q   <= done & !push;
            err_q   <= dval_i & sop_i & open_q;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {packet_num_i, zero_num_i, crc};
        end
    end

    assign {head_pnum_o, head_znum_o, head_crc_o} = mem_q[rptr_q];
    assign level_o = level_q;
    assign ovf_o   = ovf_q;
    assign err_o   = err_q;

endmodule

module merge_goback_sched #(
    parameter int DATA_W  = 32,
    parameter int PNUM_W  = 4,
    parameter int ZNUM_W  = 12,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_sop,
    input  logic              a_eop,
    input  logic              a_dval,
    input  logic [PNUM_W-1:0] a_packet_num,
    input  logic [ZNUM_W-1:0] a_zero_num,
    input  logic [DATA_W-1:0] a_dout,
    input  logic              b_sop,
    input  logic              b_eop,
    input  logic              b_dval,
    input  logic [PNUM_W-1:0] b_packet_num,
    input  logic [ZNUM_W-1:0] b_zero_num,
    input  logic [DATA_W-1:0] b_dout,
    output logic              gb_valid,
    input  logic              gb_ready,
    output logic              gb_lane,
    output logic [PNUM_W-1:0] gb_packet_num,
    output logic [ZNUM_W-1:0] gb_zero_num,
    output logic [DATA_W-1:0] gb_crc,
    output logic              a_ovf,
    output logic              b_ovf,
    output logic              a_err,
    output logic              b_err,
    output logic [FIFO_AW:0]  a_level,
    output logic [FIFO_AW:0]  b_level
);

    logic [PNUM_W-1:0] a_hp, b_hp;
    logic [ZNUM_W-1:0] a_hz, b_hz;
    logic [DATA_W-1:0] a_hc, b_hc;
    logic              pop_a, pop_b;
    logic              a_ne, b_ne, sel_b, slot_free;

    logic              valid_q;
    logic              lane_q;
    logic [PNUM_W-1:0] pnum_q;
    logic [ZNUM_W-1:0] znum_q;
    logic [DATA_W-1:0] crc_q;
    // 0 = A granted last, 1 = B granted last.
    logic              last_q;

    merge_goback_lane #(
        .DATA_W (DATA_W),
        .PNUM_W (PNUM_W),
        .ZNUM_W (ZNUM_W),
        .FIFO_AW(FIFO_AW)
    ) u_lane_a (
        .clk         (clk),
        .rst         (rst),
        .sop_i       (a_sop),
        .eop_i       (a_eop),
        .dval_i      (a_dval),
        .packet_num_i(a_packet_num),
        .zero_num_i  (a_zero_num),
        .dout_i      (a_dout),
        .pop_i       (pop_a),
        .head_pnum_o (a_hp),
        .head_znum_o (a_hz),
        .head_crc_o  (a_hc),
        .level_o     (a_level),
        .ovf_o       (a_ovf),
        .err_o       (a_err)
    );

    merge_goback_lane #(
        .DATA_W (DATA_W),
        .PNUM_W (PNUM_W),
        .ZNUM_W (ZNUM_W),
        .FIFO_AW(FIFO_AW)
    ) u_lane_b (
        .clk         (clk),
        .rst         (rst),
        .sop_i       (b_sop),
        .eop_i       (b_eop),
        .dval_i      (b_dval),
        .packet_num_i(b_packet_num),
        .zero_num_i  (b_zero_num),
        .dout_i      (b_dout),
        .pop_i       (pop_b),
        .head_pnum_o (b_hp),
        .head_znum_o (b_hz),
        .head_crc_o  (b_hc),
        .level_o     (b_level),
        .ovf_o       (b_ovf),
        .err_o       (b_err)
    );

    assign a_ne      = |a_level;
    assign b_ne      = |b_level;
    assign slot_free = !valid_q | gb_ready;
    // B wins when A is empty or A took the previous grant.
    assign sel_b     = b_ne & (!a_ne | !last_q);
    assign pop_a     = slot_free & a_ne & !sel_b;
    assign pop_b     = slot_free & sel_b;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            lane_q  <= 1'b0;
            pnum_q  <= '0;
            znum_q  <= '0;
            crc_q   <= '0;
            last_q  <= 1'b1;
        end else if (slot_free) begin
            valid_q <= a_ne | b_ne;
            if (a_ne | b_ne) begin
                lane_q <= sel_b;
                last_q <= sel_b;
                pnum_q <= sel_b ? b_hp : a_hp;
                znum_q <= sel_b ? b_hz : a_hz;
                crc_q  <= sel_b ? b_hc : a_hc;
            end
        end
    end

    assign gb_valid      = valid_q;
    assign gb_lane       = lane_q;
    assign gb_packet_num = pnum_q;
    assign gb_zero_num   = znum_q;
    assign gb_crc        = crc_q;

endmodule

// File: tb/tb_merge_goback_sched.sv
// Bench for merge_goback_sched: directed scenarios plus random traffic
// compared every cycle against a queue-based packet model.

module tb_merge_goback_sched;

    typedef struct packed {
        logic [3:0]  p;
        logic [11:0] z;
        logic [31:0] c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_sop, a_eop, a_dval, b_sop, b_eop, b_dval;
    logic [3:0]  a_packet_num, b_packet_num;
    logic [11:0] a_zero_num, b_zero_num;
    logic [31:0] a_dout, b_dout;
    logic        gb_valid, gb_ready, gb_lane;
    logic [3:0]  gb_packet_num;
    logic [11:0] gb_zero_num;
    logic [31:0] gb_crc;
    logic        a_ovf, b_ovf, a_err, b_err;
    logic [2:0]  a_level, b_level;

    int checks = 0;
    int failures = 0;

    // model state
    ent_t        qa[$];
    ent_t        qb[$];
    logic        m_valid, m_lane, m_last;
    logic [3:0]  m_pnum;
    logic [11:0] m_znum;
    logic [31:0] m_crc;
    logic        m_ovf [2];
    logic        m_err [2];
    logic        m_open [2];
    logic [31:0] m_acc [2];

    merge_goback_sched dut (
        .clk          (clk),
        .rst          (rst),
        .a_sop        (a_sop),
        .a_eop        (a_eop),
        .a_dval       (a_dval),
        .a_packet_num (a_packet_num),
        .a_zero_num   (a_zero_num),
        .a_dout       (a_dout),
        .b_sop        (b_sop),
        .b_eop        (b_eop),
        .b_dval       (b_dval),
        .b_packet_num (b_packet_num),
        .b_zero_num   (b_zero_num),
        .b_dout       (b_dout),
        .gb_valid     (gb_valid),
        .gb_ready     (gb_ready),
        .gb_lane      (gb_lane),
        .gb_packet_num(gb_packet_num),
        .gb_zero_num  (gb_zero_num),
        .gb_crc       (gb_crc),
        .a_ovf        (a_ovf),
        .b_ovf        (b_ovf),
        .a_err        (a_err),
        .b_err        (b_err),
        .a_level      (a_level),
        .b_level      (b_level)
    );

    always #5 clk = ~clk;

    function automatic logic [59:0] obs();
        return {gb_valid, gb_lane, gb_packet_num, gb_zero_num, gb_crc,
                a_ovf, b_ovf, a_err, b_err, a_level, b_level};
    endfunction

    function automatic logic [59:0] expv();
        logic [2:0] la, lb;
        la = 3'(qa.size());
        lb = 3'(qb.size());
        return {m_valid, m_lane, m_pnum, m_znum, m_crc,
                m_ovf[0], m_ovf[1], m_err[0], m_err[1], la, lb};
    endfunction

    // One lane's packet rules: a packet's CRC is the XOR of its partials.
    task automatic lane_model(input logic sop, input logic eop, input logic dv,
                              input logic [31:0] d, inout logic open,
                              inout logic [31:0] acc, output logic done,
                              output logic [31:0] crc, output logic err);
        done = 1'b0;
        crc  = 32'h0;
        err  = dv & sop & open;
        if (dv && sop) begin
            acc  = d;
            open = !eop;
            done = eop;
            crc  = d;
        end else if (dv && open) begin
            acc = acc ^ d;
            if (eop) begin
                open = 1'b0;
                done = 1'b1;
                crc  = acc;
            end
        end
    endtask

    task automatic model_edge();
        logic da, db, ea, eb;
        logic [31:0] ca, cb;
        ent_t e;
        if (!rst) begin
            qa.delete();
            qb.delete();
            m_valid = 0; m_lane = 0; m_pnum = 0; m_znum = 0; m_crc = 0;
            m_last = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_ovf[i] = 0; m_err[i] = 0; m_open[i] = 0; m_acc[i] = 0;
            end
            return;
        end
        lane_model(a_sop, a_eop, a_dval, a_dout, m_open[0], m_acc[0], da, ca, ea);
        lane_model(b_sop, b_eop, b_dval, b_dout, m_open[1], m_acc[1], db, cb, eb);
        // pops see only entries queued before this edge
        if (!m_valid || gb_ready) begin
            if (qa.size() > 0 && (qb.size() == 0 || m_last)) begin
                e = qa.pop_front();
                m_valid = 1; m_lane = 0; m_last = 0;
                m_pnum = e.p; m_znum = e.z; m_crc = e.c;
            end else if (qb.size() > 0) begin
                e = qb.pop_front();
                m_valid = 1; m_lane = 1; m_last = 1;
                m_pnum = e.p; m_znum = e.z; m_crc = e.c;
            end else begin
                m_valid = 0;
            end
        end
        m_ovf[0] = 0;
        m_ovf[1] = 0;
        if (da) begin
            if (qa.size() < 4) qa.push_back('{a_packet_num, a_zero_num, ca});
            else m_ovf[0] = 1;
        end
        if (db) begin
            if (qb.size() < 4) qb.push_back('{b_packet_num, b_zero_num, cb});
            else m_ovf[1] = 1;
        end
        m_err[0] = ea;
        m_err[1] = eb;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        a_sop = 0; a_eop = 0; a_dval = 0; a_dout = 0;
        a_packet_num = 0; a_zero_num = 0;
        b_sop = 0; b_eop = 0; b_dval = 0; b_dout = 0;
        b_packet_num = 0; b_zero_num = 0;
    endtask

    task automatic drv_a(input logic s, input logic e, input logic [3:0] p,
                         input logic [11:0] z, input logic [31:0] d);
        a_dval = 1; a_sop = s; a_eop = e;
        a_packet_num = p; a_zero_num = z; a_dout = d;
    endtask

    task automatic drv_b(input logic s, input logic e, input logic [3:0] p,
                         input logic [11:0] z, input logic [31:0] d);
        b_dval = 1; b_sop = s; b_eop = e;
        b_packet_num = p; b_zero_num = z; b_dout = d;
    endtask

    task automatic test_reset();
        idle();
        gb_ready = 1;
        rst = 0;
        step();
        step();
        checks++;
        if (obs() !== 60'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", obs());
        end
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_model got=%h want=%h", obs(), expv());
        end
        rst = 1;
        step();
    endtask

    task automatic test_single();
        gb_ready = 1;
        drv_a(1, 1, 4'd3, 12'd5, 32'h1234_5678);
        step();
        idle();
        checks++;
        if (gb_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_early got=%b want=0", gb_valid);
        end
        step();
        checks++;
        if ({gb_valid, gb_lane, gb_packet_num, gb_zero_num, gb_crc} !==
            {1'b1, 1'b0, 4'd3, 12'd5, 32'h1234_5678}) begin
            failures++;
            $display("FAIL single_req got=%b/%b/%0d/%0d/%h want=1/0/3/5/12345678",
                     gb_valid, gb_lane, gb_packet_num, gb_zero_num, gb_crc);
        end
        step();
        checks++;
        if (gb_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse got=%b want=0", gb_valid);
        end
    endtask

    task automatic test_multi_b();
        gb_ready = 1;
        drv_b(1, 0, 4'd7, 12'd9, 32'hF0F0_0000);
        step();
        drv_b(0, 0, 4'd7, 12'd9, 32'h0F0F_0000);
        step();
        drv_b(0, 1, 4'd7, 12'd9, 32'h0000_00FF);
        step();
        idle();
        step();
        checks++;
        if ({gb_valid, gb_lane, gb_packet_num, gb_zero_num, gb_crc} !==
            {1'b1, 1'b1, 4'd7, 12'd9, 32'hFFFF_00FF}) begin
            failures++;
            $display("FAIL multi_b got=%b/%b/%0d/%0d/%h want=1/1/7/9/ffff00ff",
                     gb_valid, gb_lane, gb_packet_num, gb_zero_num, gb_crc);
        end
        step();
    endtask

    task automatic test_alternation();
        int n;
        logic [7:0] lanes;
        n = 0;
        lanes = 0;
        gb_ready = 1;
        for (int r = 0; r < 4; r++) begin
            drv_a(1, 1, 4'(2 * r), 12'(r), $urandom);
            drv_b(1, 1, 4'(2 * r + 1), 12'(r), $urandom);
            step();
            if (gb_valid && n < 8) begin
                lanes[n] = gb_lane;
                n++;
            end
        end
        idle();
        for (int k = 0; k < 12 && n < 8; k++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL alt_model got=%h want=%h", obs(), expv());
            end
            if (gb_valid) begin
                lanes[n] = gb_lane;
                n++;
            end
        end
        checks++;
        if (n != 8 || lanes !== 8'b1010_1010) begin
            failures++;
            $display("FAIL alt_order got=%b (%0d grants) want=10101010 (8)", lanes, n);
        end
        step();
    endtask

    task automatic test_overflow();
        logic [31:0] held;
        int n;
        logic [19:0] seq;
        gb_ready = 0;
        held = 0;
        for (int i = 0; i < 6; i++) begin
            drv_a(1, 1, 4'(i + 1), 12'(i), $urandom);
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL ovf_model i=%0d got=%h want=%h", i, obs(), expv());
            end
            if (i == 1) held = gb_crc;
        end
        idle();
        checks++;
        if ({a_ovf, a_level} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL ovf_pulse got=%b/%0d want=1/4", a_ovf, a_level);
        end
        step();
        step();
        checks++;
        if ({gb_valid, gb_packet_num, gb_crc, a_ovf} !== {1'b1, 4'd1, held, 1'b0}) begin
            failures++;
            $display("FAIL ovf_hold got=%b/%0d/%h/%b want=1/1/%h/0",
                     gb_valid, gb_packet_num, gb_crc, a_ovf, held);
        end
        gb_ready = 1;
        n = 0;
        seq = 0;
        for (int k = 0; k < 10; k++) begin
            if (gb_valid && n < 5) begin
                seq[n*4 +: 4] = gb_packet_num;
                n++;
            end
            step();
        end
        checks++;
        if (n != 5 || seq !== 20'h54321) begin
            failures++;
            $display("FAIL ovf_drain got=%h (%0d) want=54321 (5)", seq, n);
        end
    endtask

    task automatic test_err();
        int errs;
        int k;
        errs = 0;
        gb_ready = 1;
        drv_a(1, 0, 4'd2, 12'd4, 32'hDEAD_BEEF);
        step();
        errs += int'(a_err);
        drv_a(0, 0, 4'd2, 12'd4, 32'h0BAD_F00D);
        step();
        errs += int'(a_err);
        drv_a(1, 0, 4'd2, 12'd4, 32'hA5A5_0000);
        step();
        errs += int'(a_err);
        drv_a(0, 0, 4'd2, 12'd4, 32'h0000_5A5A);
        step();
        errs += int'(a_err);
        drv_a(0, 1, 4'd2, 12'd4, 32'h1111_1111);
        step();
        errs += int'(a_err);
        idle();
        checks++;
        if (errs != 1) begin
            failures++;
            $display("FAIL err_pulses got=%0d want=1", errs);
        end
        k = 0;
        while (!gb_valid && k < 5) begin
            step();
            k++;
        end
        checks++;
        if ({gb_valid, gb_lane, gb_crc} !== {1'b1, 1'b0, 32'hB4B4_4B4B}) begin
            failures++;
            $display("FAIL err_crc got=%b/%b/%h want=1/0/b4b44b4b",
                     gb_valid, gb_lane, gb_crc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int k;
        gb_ready = 0;
        drv_a(1, 1, 4'd9, 12'd1, 32'h5555_AAAA);
        step();
        idle();
        drv_b(1, 0, 4'd6, 12'd2, 32'h7777_7777);
        step();
        idle();
        checks++;
        if (gb_valid !== 1'b1) begin
            failures++;
            $display("FAIL rmid_setup got=%b want=1", gb_valid);
        end
        rst = 0;
        step();
        checks++;
        if (obs() !== 60'h0) begin
            failures++;
            $display("FAIL rmid_clear got=%h want=0", obs());
        end
        rst = 1;
        gb_ready = 1;
        step();
        drv_b(0, 1, 4'd6, 12'd2, 32'h1111_1111);
        step();
        drv_b(1, 0, 4'd8, 12'd3, 32'h1357_9BDF);
        step();
        drv_b(0, 1, 4'd8, 12'd3, 32'h0000_FFFF);
        step();
        idle();
        k = 0;
        while (!gb_valid && k < 5) begin
            step();
            k++;
        end
        checks++;
        if ({gb_valid, gb_lane, gb_packet_num, gb_zero_num, gb_crc} !==
            {1'b1, 1'b1, 4'd8, 12'd3, 32'h1357_6420}) begin
            failures++;
            $display("FAIL rmid_clean got=%b/%b/%0d/%0d/%h want=1/1/8/3/13576420",
                     gb_valid, gb_lane, gb_packet_num, gb_zero_num, gb_crc);
        end
        step();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) != 0);
            gb_ready = ($urandom_range(0, 3) != 0);
            a_dval = $urandom_range(0, 1);
            a_sop = ($urandom_range(0, 3) == 0);
            a_eop = ($urandom_range(0, 2) == 0);
            a_packet_num = 4'($urandom);
            a_zero_num = 12'($urandom);
            a_dout = $urandom;
            b_dval = $urandom_range(0, 1);
            b_sop = ($urandom_range(0, 3) == 0);
            b_eop = ($urandom_range(0, 2) == 0);
            b_packet_num = 4'($urandom);
            b_zero_num = 12'($urandom);
            b_dout = $urandom;
            step();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_cycle c=%0d got=%h want=%h", c, obs(), expv());
            end
        end
        rst = 1;
        idle();
        step();
    endtask

    initial begin
        rst = 0;
        gb_ready = 1;
        idle();
        test_reset();
        test_single();
        test_multi_b();
        test_alternation();
        test_overflow();
        test_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
